// File: rtl/stack_calc_ctrl.sv
`default_nettype none
// stack_calc_ctrl: token-driven infix calculator sequencer ('*','/' bind tighter than '+','-')
// that drives an external req/ack ALU.  Rev 1.0
module stack_calc_ctrl #(
  parameter int MAX_DIGITS = 9
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tok_valid,
  input  logic [3:0]  tok,
  output logic        tok_ready,
  output logic        alu_req,
  output logic [1:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic        alu_ack,
  input  logic [31:0] alu_result,
  input  logic        alu_err,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        error,
  output logic        busy,
  output logic [2:0]  state
);

  localparam int                 C_CNT_W   = $clog2(MAX_DIGITS + 1);
  localparam logic [C_CNT_W-1:0] C_MAX_CNT = C_CNT_W'(MAX_DIGITS);
  localparam logic [3:0] C_TOK_ADD = 4'hA;
  localparam logic [3:0] C_TOK_SUB = 4'hB;
  localparam logic [3:0] C_TOK_MUL = 4'hC;
  localparam logic [3:0] C_TOK_DIV = 4'hD;
  localparam logic [3:0] C_TOK_CLR = 4'hF;

  typedef enum logic [2:0] {
    S_OPND    = 3'd0,
    S_MUL_REQ = 3'd1,
    S_ADD_REQ = 3'd2,
    S_DONE    = 3'd3,
    S_ERR     = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          acc_q, acc_d, term_q, term_d, num_q, num_d;
  logic                 add_op_q, add_op_d;           // 0 '+', 1 '-'
  logic [1:0]           mul_op_q, mul_op_d;           // 00 none, 10 mul, 11 div
  logic                 have_digit_q, have_digit_d;
  logic [C_CNT_W-1:0]   digit_cnt_q, digit_cnt_d;
  logic [3:0]           pend_q, pend_d;
  logic                 alu_req_q, alu_req_d;
  logic [1:0]           alu_op_q, alu_op_d;
  logic [31:0]          alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [31:0]          result_q, result_d;
  logic                 result_valid_q, result_valid_d;
  logic                 error_q, error_d;

  logic w_is_digit, w_is_muldiv, w_is_clr, w_pend_muldiv, w_pend_addsub, w_accept, w_ack;
  logic clr_all, new_digit;

  assign w_is_digit    = (tok <= 4'd9);
  assign w_is_muldiv   = (tok == C_TOK_MUL) || (tok == C_TOK_DIV);
  assign w_is_clr      = (tok == C_TOK_CLR);
  assign w_pend_muldiv = (pend_q == C_TOK_MUL) || (pend_q == C_TOK_DIV);
  assign w_pend_addsub = (pend_q == C_TOK_ADD) || (pend_q == C_TOK_SUB);
  assign tok_ready     = (state_q == S_OPND) || (state_q == S_DONE) || (state_q == S_ERR);
  assign w_accept      = tok_valid && tok_ready;
  assign w_ack         = alu_ack && alu_req_q;

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    term_d         = term_q;
    num_d          = num_q;
    add_op_d       = add_op_q;
    mul_op_d       = mul_op_q;
    have_digit_d   = have_digit_q;
    digit_cnt_d    = digit_cnt_q;
    pend_d         = pend_q;
    alu_req_d      = alu_req_q;
    alu_op_d       = alu_op_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    error_d        = error_q;
    clr_all        = 1'b0;
    new_digit      = 1'b0;

    case (state_q)
      S_OPND: begin
        if (w_accept) begin
          if (w_is_clr) begin
            clr_all = 1'b1;
          end else if (w_is_digit) begin
            if (digit_cnt_q < C_MAX_CNT) begin
              num_d        = num_q * 32'd10 + {28'd0, tok};
              have_digit_d = 1'b1;
              digit_cnt_d  = digit_cnt_q + C_CNT_W'(1);
            end
          end else if (have_digit_q) begin
            // A pending '*'/'/' must be reduced before anything else happens.
            if (mul_op_q != 2'b00) begin
              pend_d    = tok;
              state_d   = S_MUL_REQ;
              alu_req_d = 1'b1;
              alu_op_d  = mul_op_q;
              alu_a_d   = term_q;
              alu_b_d   = num_q;
            end else begin
              term_d = num_q;
              if (w_is_muldiv) begin
                mul_op_d     = {1'b1, tok[0]};
                num_d        = '0;
                have_digit_d = 1'b0;
                digit_cnt_d  = '0;
              end else begin
                pend_d    = tok;
                state_d   = S_ADD_REQ;
                alu_req_d = 1'b1;
                alu_op_d  = {1'b0, add_op_q};
                alu_a_d   = acc_q;
                alu_b_d   = num_q;
              end
            end
          end
        end
      end
      S_MUL_REQ: begin
        if (w_ack) begin
          alu_req_d = 1'b0;
          if (alu_err) begin
            error_d = 1'b1;
            state_d = S_ERR;
          end else begin
            term_d = alu_result;
            if (w_pend_muldiv) begin
              mul_op_d     = {1'b1, pend_q[0]};
              num_d        = '0;
              have_digit_d = 1'b0;
              digit_cnt_d  = '0;
              state_d      = S_OPND;
            end else begin
              // Back-to-back request: the product goes straight into the sum.
              state_d   = S_ADD_REQ;
              alu_req_d = 1'b1;
              alu_op_d  = {1'b0, add_op_q};
              alu_a_d   = acc_q;
              alu_b_d   = alu_result;
            end
          end
        end
      end
      S_ADD_REQ: begin
        if (w_ack) begin
          alu_req_d = 1'b0;
          if (alu_err) begin
            error_d = 1'b1;
            state_d = S_ERR;
          end else begin
            acc_d    = alu_result;
            mul_op_d = 2'b00;
            if (w_pend_addsub) begin
              add_op_d     = pend_q[0];
              num_d        = '0;
              have_digit_d = 1'b0;
              digit_cnt_d  = '0;
              state_d      = S_OPND;
            end else begin
              result_d       = alu_result;
              result_valid_d = 1'b1;
              state_d        = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        if (w_accept) begin
          if (w_is_clr) begin
            clr_all = 1'b1;
          end else if (w_is_digit) begin
            clr_all   = 1'b1;
            new_digit = 1'b1;
          end
        end
      end
      S_ERR: begin
        if (w_accept && w_is_clr) clr_all = 1'b1;
      end
      default: state_d = S_OPND;
    endcase

    if (clr_all) begin
      state_d        = S_OPND;
      acc_d          = '0;
      term_d         = '0;
      num_d          = '0;
      add_op_d       = 1'b0;
      mul_op_d       = 2'b00;
      have_digit_d   = 1'b0;
      digit_cnt_d    = '0;
      pend_d         = '0;
      alu_req_d      = 1'b0;
      alu_op_d       = 2'b00;
      alu_a_d        = '0;
      alu_b_d        = '0;
      result_d       = '0;
      result_valid_d = 1'b0;
      error_d        = 1'b0;
    end
    if (new_digit) begin
      num_d        = {28'd0, tok};
      have_digit_d = 1'b1;
      digit_cnt_d  = C_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_OPND;
      acc_q          <= '0;
      term_q         <= '0;
      num_q          <= '0;
      add_op_q       <= 1'b0;
      mul_op_q       <= 2'b00;
      have_digit_q   <= 1'b0;
      digit_cnt_q    <= '0;
      pend_q         <= '0;
      alu_req_q      <= 1'b0;
      alu_op_q       <= 2'b00;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      term_q         <= term_d;
      num_q          <= num_d;
      add_op_q       <= add_op_d;
      mul_op_q       <= mul_op_d;
      have_digit_q   <= have_digit_d;
      digit_cnt_q    <= digit_cnt_d;
      pend_q         <= pend_d;
      alu_req_q      <= alu_req_d;
      alu_op_q       <= alu_op_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      error_q        <= error_d;
    end
  end

  assign alu_req      = alu_req_q;
  assign alu_op       = alu_op_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign error        = error_q;
  assign busy         = (state_q == S_MUL_REQ) || (state_q == S_ADD_REQ);
  assign state        = state_q;

endmodule
`default_nettype wire

// File: tb/tb_stack_calc_ctrl.sv
`default_nettype none
// tb_stack_calc_ctrl: directed expression vectors with a scripted ALU responder.  Rev 1.0
module tb_stack_calc_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        tok_valid;
  logic [3:0]  tok;
  logic        tok_ready;
  logic        alu_req;
  logic [1:0]  alu_op;
  logic [31:0] alu_a, alu_b;
  logic        alu_ack;
  logic [31:0] alu_result;
  logic        alu_err;
  logic [31:0] result;
  logic        result_valid, error, busy;
  logic [2:0]  state;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  stack_calc_ctrl #(.MAX_DIGITS(9)) dut (
    .clk(clk), .reset_n(reset_n), .tok_valid(tok_valid), .tok(tok), .tok_ready(tok_ready),
    .alu_req(alu_req), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_ack(alu_ack),
    .alu_result(alu_result), .alu_err(alu_err), .result(result), .result_valid(result_valid),
    .error(error), .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] t);
    int n;
    n = 0;
    @(negedge clk);
    tok_valid = 1'b1;
    tok       = t;
    while (!tok_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!tok_ready) check1("tok_accept_timeout", tok_ready, 1'b1);
    @(posedge clk);
    #1;
    tok_valid = 1'b0;
  endtask

  // Waits for a request, checks its operands, holds them for dly cycles, then acks.
  task automatic alu_txn(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input logic err,
                         input int dly, input logic req_after);
    int n;
    n = 0;
    @(negedge clk);
    while (!alu_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check1({tag, "_req"}, alu_req, 1'b1);
    check({tag, "_op"}, 32'(alu_op), 32'(op));
    check({tag, "_a"}, alu_a, a);
    check({tag, "_b"}, alu_b, b);
    repeat (dly) begin
      @(negedge clk);
      check1({tag, "_hold_req"}, alu_req, 1'b1);
      check1({tag, "_hold_rdy"}, tok_ready, 1'b0);
      check({tag, "_hold_op"}, 32'(alu_op), 32'(op));
      check({tag, "_hold_a"}, alu_a, a);
      check({tag, "_hold_b"}, alu_b, b);
    end
    alu_ack    = 1'b1;
    alu_result = res;
    alu_err    = err;
    @(posedge clk);
    #1;
    alu_ack = 1'b0;
    alu_err = 1'b0;
    check1({tag, "_req_after"}, alu_req, req_after);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    tok_valid  = 1'b0;
    tok        = 4'h0;
    alu_ack    = 1'b0;
    alu_result = 32'd0;
    alu_err    = 1'b0;
    #12;
    check("rst_state", 32'(state), 32'd0);
    check1("rst_ready", tok_ready, 1'b1);
    check1("rst_req", alu_req, 1'b0);
    check("rst_result", result, 32'd0);
    check1("rst_valid", result_valid, 1'b0);
    check1("rst_error", error, 1'b0);
    check1("rst_busy", busy, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Operator with no digits is ignored.
    send(4'hA);
    check("noop_state", 32'(state), 32'd0);
    check1("noop_req", alu_req, 1'b0);

    // 12+3=
    send(4'h1); send(4'h2); send(4'hA);
    check1("e1_busy", busy, 1'b1);
    alu_txn("e1_add0", 2'b00, 32'd0, 32'd12, 32'd12, 1'b0, 0, 1'b0);
    send(4'h3); send(4'hE);
    alu_txn("e1_add1", 2'b00, 32'd12, 32'd3, 32'd15, 1'b0, 0, 1'b0);
    check("e1_result", result, 32'h0000000F);
    check1("e1_valid", result_valid, 1'b1);
    check("e1_state", 32'(state), 32'd3);

    // 2+3*4= started straight from DONE
    send(4'h2);
    check("e2_state_new", 32'(state), 32'd0);
    check1("e2_valid_clr", result_valid, 1'b0);
    send(4'hA);
    alu_txn("e2_add0", 2'b00, 32'd0, 32'd2, 32'd2, 1'b0, 0, 1'b0);
    send(4'h3); send(4'hC);
    check("e2_mul_latch_state", 32'(state), 32'd0);
    check1("e2_mul_latch_req", alu_req, 1'b0);
    send(4'h4); send(4'hE);
    alu_txn("e2_mul", 2'b10, 32'd3, 32'd4, 32'd12, 1'b0, 0, 1'b1);
    alu_txn("e2_add1", 2'b00, 32'd2, 32'd12, 32'd14, 1'b0, 0, 1'b0);
    check("e2_result", result, 32'd14);
    check("e2_state", 32'(state), 32'd3);

    // 9-4=
    send(4'h9); send(4'hB);
    alu_txn("e3_add0", 2'b00, 32'd0, 32'd9, 32'd9, 1'b0, 0, 1'b0);
    send(4'h4); send(4'hE);
    alu_txn("e3_sub", 2'b01, 32'd9, 32'd4, 32'd5, 1'b0, 0, 1'b0);
    check("e3_result", result, 32'd5);

    // 8/0= with ALU fault
    send(4'hF);
    check1("clr_valid", result_valid, 1'b0);
    send(4'h8); send(4'hD); send(4'h0); send(4'hE);
    alu_txn("e4_div", 2'b11, 32'd8, 32'd0, 32'd0, 1'b1, 0, 1'b0);
    check1("e4_error", error, 1'b1);
    check("e4_state", 32'(state), 32'd4);
    send(4'h5);
    check("e4_ignore_state", 32'(state), 32'd4);
    check1("e4_ignore_error", error, 1'b1);
    send(4'hF);
    check1("e4_clr_error", error, 1'b0);
    check("e4_clr_state", 32'(state), 32'd0);
    check("e4_clr_result", result, 32'd0);

    // Ten 9s: the tenth digit is discarded
    repeat (10) send(4'h9);
    send(4'hE);
    alu_txn("e5_add", 2'b00, 32'd0, 32'd999999999, 32'd999999999, 1'b0, 0, 1'b0);
    check("e5_result", result, 32'h3B9AC9FF);

    // Slow ALU with '+' held on the token port
    send(4'hF);
    send(4'h1); send(4'hA);
    tok_valid = 1'b1;
    tok       = 4'hA;
    alu_txn("e6_slow", 2'b00, 32'd0, 32'd1, 32'd1, 1'b0, 5, 1'b0);
    check1("e6_ready_back", tok_ready, 1'b1);
    check("e6_state_back", 32'(state), 32'd0);
    @(posedge clk);
    #1;
    tok_valid = 1'b0;
    check("e6_state_after", 32'(state), 32'd0);
    check1("e6_req_after", alu_req, 1'b0);

    // Asynchronous reset mid-transaction
    send(4'hF);
    send(4'h7); send(4'hA);
    @(negedge clk);
    check1("e7_req_before", alu_req, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check1("e7_req_async", alu_req, 1'b0);
    check("e7_state_async", 32'(state), 32'd0);
    check1("e7_busy_async", busy, 1'b0);
    check1("e7_ready_async", tok_ready, 1'b1);
    @(negedge clk);
    reset_n    = 1'b1;
    alu_ack    = 1'b1;
    alu_result = 32'd123;
    @(posedge clk);
    #1;
    alu_ack = 1'b0;
    check("e7_late_ack_state", 32'(state), 32'd0);
    check1("e7_late_ack_valid", result_valid, 1'b0);
    check("e7_late_ack_result", result, 32'd0);
    send(4'h1); send(4'hA);
    alu_txn("e7_add0", 2'b00, 32'd0, 32'd1, 32'd1, 1'b0, 0, 1'b0);
    send(4'h1); send(4'hE);
    alu_txn("e7_add1", 2'b00, 32'd1, 32'd1, 32'd2, 1'b0, 0, 1'b0);
    check("e7_result", result, 32'd2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
